// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter with a small byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t         state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [7:0]     shift;
    logic [15:0]    baud_cnt;
    logic [2:0]     bit_idx;
`ifdef UART_TX_PARITY_EN
    logic           par;
`endif

    logic       baud_done;
    logic       push;
    logic       pop;
    logic [7:0] head;

    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign baud_done = (baud_cnt == BAUD_MAX);
    assign push      = wr_en && !full;
    assign head      = mem[rd_ptr];
    // A pop happens on leaving IDLE or at the end of a stop bit.
    assign pop       = (fifo_count != '0) &&
                       ((state == IDLE) || ((state == STOP) && baud_done));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            shift      <= '0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            tx         <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end

            if (state != IDLE) begin
                baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= head;
                        tx       <= 1'b0;
                        baud_cnt <= '0;
                        state    <= START;
`ifdef UART_TX_PARITY_EN
                        par      <= ^head;
`endif
                    end
                end
                START: begin
                    if (baud_done) begin
                        tx      <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_done) begin
                        if (pop) begin
                            shift <= head;
                            tx    <= 1'b0;
                            state <= START;
`ifdef UART_TX_PARITY_EN
                            par   <= ^head;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
